vend_sequencer: RTL and testbench
=================================

// Module: vend_sequencer
// PURPOSE
//  Sequences the physical dispense for the vending machine's soda/change decision.
//  - Takes each soda_i pulse plus its change code (count of nickels, 0..4) into a small request queue.
//  - Drives the soda motor with a done handshake and a timeout.
//  - Then pays change one nickel at a time through a coin hopper, using a ready/pulse handshake.
//  - Sits between the vending_machine decision logic and the motor/hopper drivers.
// PARAMETERS
//  QDEPTH         2    request queue depth (entries; power of two, >=2)
//  MOTOR_TIMEOUT  255  max cycles in MOTOR without motor_done_i before FAULT (>=1)
//  NICKEL_GAP     2    idle cycles between consecutive nickel_o pulses (>=1)
// PORTS
//  clk_i           in   1  clock, rising edge
//  rst_ni          in   1  reset, asynchronous, active-low
//  soda_i          in   1  dispense request, sampled each cycle
//  change_i        in   3  nickels owed with this request (valid when soda_i=1)
//  motor_done_i    in   1  motor driver reports the can has dropped
//  hopper_ready_i  in   1  hopper can accept a nickel this cycle
//  clear_fault_i   in   1  leave FAULT (level; acted on only in FAULT)
//  motor_o         out  1  soda motor enable
//  nickel_o        out  1  one-cycle pulse = eject one nickel
//  busy_o          out  1  queue non-empty or FSM not IDLE
//  overflow_o      out  1  sticky: a request was dropped because the queue was full
//  fault_o         out  1  motor timeout; high while in FAULT
// BEHAVIOUR
//  Reset (rst_ni=0, any time, async):
//   - queue empty, FSM=IDLE, all counters 0.
//   - motor_o, nickel_o, busy_o, overflow_o and fault_o all 0.
//   - An operation in progress is abandoned with no nickel owed.
//  Queue:
//   - soda_i=1 with queue not full pushes change_i at that edge.
//   - change_i values 5..7 are clamped to 4 before the push.
//   - soda_i=1 with queue full: the request is dropped and overflow_o is set (sticky).
//   - A push and a pop in the same cycle on a full queue: the push is accepted.
//   - While in FAULT, soda_i is ignored (no push, no overflow).
//  FSM, all outputs registered:
//   - IDLE: if the queue is non-empty, pop the head into cnt and go to MOTOR.
//     - motor_o is high 2 cycles after the cycle soda_i was sampled (empty queue, FSM IDLE).
//   - MOTOR: motor_o=1; tmr increments each cycle.
//     - On motor_done_i=1, go to CHANGE if cnt>0, else IDLE.
//     - If tmr reaches MOTOR_TIMEOUT with no done, go to FAULT.
//     - done and timeout in the same cycle: done wins.
//   - CHANGE: motor_o=0; wait for hopper_ready_i=1.
//     - When it is high, pulse nickel_o for 1 cycle and decrement cnt.
//     - After the pulse, go to IDLE if the new cnt is 0, else GAP.
//   - GAP: count NICKEL_GAP cycles, then return to CHANGE.
//     - Nickel pulses are therefore separated by at least NICKEL_GAP low cycles.
//   - FAULT: entered from MOTOR. On entry the queue is flushed and cnt is cleared.
//     - motor_o=0, fault_o=1. Stay until clear_fault_i=1, then go to IDLE next edge.
//  Other rules:
//   - motor_done_i outside MOTOR and hopper_ready_i outside CHANGE are ignored.
//   - Back-to-back requests: IDLE pops the next entry on the cycle after the previous job finishes.
//   - busy_o is combinational from registered state: (state!=IDLE) | (count!=0).
//   - tmr and GAP counter widths: $clog2(param+1); no wrap-around is possible.
// TESTING
//  1. soda_i=1, change_i=0 at cycle 0; motor_done_i at cycle 5
//     -> motor_o=1 in cycles 2..5; nickel_o never pulses; busy_o=0 from cycle 6.
//  2. change_i=3, hopper_ready_i held high, NICKEL_GAP=2
//     -> exactly 3 nickel_o pulses, each followed by 2 low cycles; then IDLE.
//  3. Three soda_i pulses on consecutive cycles with QDEPTH=2 and the FSM busy
//     -> first two requests are served in order; the third is dropped; overflow_o=1 until reset.
//  4. Withhold motor_done_i, MOTOR_TIMEOUT=8
//     -> fault_o=1 after 8 MOTOR cycles; motor_o=0; queue flushed; soda_i ignored;
//        clear_fault_i -> IDLE with busy_o=0.
//  5. change_i=6 -> exactly 4 nickel pulses.
//     hopper_ready_i low for 10 cycles -> no pulse until it rises.
//  6. rst_ni low mid-CHANGE (2 nickels still owed)
//     -> all outputs 0 immediately; after release, no nickel_o and no motor_o without a new soda_i.

Source files
------------

// File: rtl/vend_sequencer.sv
// Dispense sequencer: queues soda requests with their change, runs the soda motor
// with a done/timeout handshake, then pays change one nickel at a time via the hopper.
module vend_sequencer #(
  parameter int QDEPTH        = 2,
  parameter int MOTOR_TIMEOUT = 255,
  parameter int NICKEL_GAP    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       soda_i,
  input  logic [2:0] change_i,
  input  logic       motor_done_i,
  input  logic       hopper_ready_i,
  input  logic       clear_fault_i,
  output logic       motor_o,
  output logic       nickel_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic       fault_o,
  output logic [2:0] dbg_state_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(MOTOR_TIMEOUT + 1);
  localparam int GW = $clog2(NICKEL_GAP + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(MOTOR_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(NICKEL_GAP - 1);
  localparam logic [CW-1:0] Q_FULL   = CW'(QDEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOTOR  = 3'd1,
    S_CHANGE = 3'd2,
    S_GAP    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        state;
  logic [2:0]    mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [2:0]    cnt;
  logic [TW-1:0] tmr;
  logic [GW-1:0] gap;

  logic       q_full;
  logic       pop;
  logic       flush;
  logic       req;
  logic       push;
  logic       drop;
  logic [2:0] change_clamped;

  always_comb begin
    q_full         = (count == Q_FULL);
    pop            = (state == S_IDLE) && (count != '0);
    flush          = (state == S_MOTOR) && !motor_done_i && (tmr == TMR_LAST);
    req            = soda_i && (state != S_FAULT);
    // A pop in the same cycle frees the slot, so a full queue still takes the push.
    push           = req && (!q_full || pop) && !flush;
    drop           = req && q_full && !pop;
    change_clamped = (change_i > 3'd4) ? 3'd4 : change_i;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= change_clamped;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
      if (drop) overflow_o <= 1'b1;
    end
  end

  // Hopper handshake: a nickel is ejected on an edge where the FSM is in CHANGE and
  // hopper_ready_i is high; nickel_o is the registered one-cycle pulse of that transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tmr      <= '0;
      gap      <= '0;
      motor_o  <= 1'b0;
      nickel_o <= 1'b0;
      fault_o  <= 1'b0;
    end else begin
      nickel_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            cnt     <= mem[rd_ptr];
            tmr     <= '0;
            motor_o <= 1'b1;
            state   <= S_MOTOR;
          end
        end
        S_MOTOR: begin
          if (motor_done_i) begin
            motor_o <= 1'b0;
            tmr     <= '0;
            state   <= (cnt != 3'd0) ? S_CHANGE : S_IDLE;
          end else if (tmr == TMR_LAST) begin
            motor_o <= 1'b0;
            fault_o <= 1'b1;
            cnt     <= '0;
            tmr     <= '0;
            state   <= S_FAULT;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_CHANGE: begin
          if (hopper_ready_i) begin
            nickel_o <= 1'b1;
            cnt      <= cnt - 3'd1;
            gap      <= '0;
            state    <= (cnt == 3'd1) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap == GAP_LAST) begin
            gap   <= '0;
            state <= S_CHANGE;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        S_FAULT: begin
          if (clear_fault_i) begin
            fault_o <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state != S_IDLE) | (count != '0);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: a monitor segments nickel pulses per job into
// got_q, which is compared against exp_q filled as requests are driven.
module tb_vend_sequencer;
  localparam int QDEPTH        = 2;
  localparam int MOTOR_TIMEOUT = 8;
  localparam int NICKEL_GAP    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soda_i, motor_done_i, hopper_ready_i, clear_fault_i;
  logic [2:0] change_i;
  logic       motor_o, nickel_o, busy_o, overflow_o, fault_o;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];

  logic       in_job     = 1'b0;
  logic       motor_prev = 1'b0;
  logic [2:0] nick_cnt   = '0;
  logic [11:0] cap, expv;
  int n;

  vend_sequencer #(
    .QDEPTH(QDEPTH), .MOTOR_TIMEOUT(MOTOR_TIMEOUT), .NICKEL_GAP(NICKEL_GAP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .soda_i(soda_i), .change_i(change_i),
    .motor_done_i(motor_done_i), .hopper_ready_i(hopper_ready_i),
    .clear_fault_i(clear_fault_i), .motor_o(motor_o), .nickel_o(nickel_o),
    .busy_o(busy_o), .overflow_o(overflow_o), .fault_o(fault_o),
    .dbg_state_o(dbg_state)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // A job starts at a motor_o rising edge and ends at the next rise or when busy_o drops.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_job = 1'b0; nick_cnt = '0; motor_prev = 1'b0;
    end else begin
      if (nickel_o === 1'b1) nick_cnt = nick_cnt + 3'd1;
      if (motor_o === 1'b1 && !motor_prev) begin
        if (in_job) got_q.push_back(nick_cnt);
        in_job = 1'b1; nick_cnt = '0;
      end else if (in_job && busy_o === 1'b0) begin
        got_q.push_back(nick_cnt);
        in_job = 1'b0; nick_cnt = '0;
      end
      motor_prev = (motor_o === 1'b1);
    end
  end

  function automatic logic [2:0] clamp(input logic [2:0] c);
    return (c > 3'd4) ? 3'd4 : c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] c);
    soda_i = 1'b1; change_i = c;
    exp_q.push_back(clamp(c));
    cyc();
    soda_i = 1'b0;
  endtask

  task automatic wait_motor(input string tag);
    int k = 0;
    while (motor_o !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk({tag, "_motor_seen"}, motor_o, 1);
  endtask

  task automatic do_done(input string tag);
    wait_motor(tag);
    motor_done_i = 1'b1;
    cyc();
    motor_done_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy_o !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    chk({tag, "_idle"}, busy_o, 0);
    @(negedge clk);
    cyc();
  endtask

  task automatic check_jobs(input string tag);
    logic [2:0] e, g;
    chk({tag, "_njobs"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_nickels"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; soda_i = 1'b0; change_i = '0; motor_done_i = 1'b0;
    hopper_ready_i = 1'b0; clear_fault_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_motor", motor_o, 0);
    chk("rst_nickel", nickel_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_state_known", $isunknown(dbg_state), 0);
    rst_n = 1'b1;
    cyc();

    // T1: zero change, motor window cycles 2..5
    soda_i = 1'b1; change_i = 3'd0; exp_q.push_back(3'd0);
    cyc();
    soda_i = 1'b0;
    @(negedge clk); chk("t1_motor_c1", motor_o, 0);
    cyc();
    for (int c = 2; c <= 5; c++) begin
      if (c == 5) motor_done_i = 1'b1;
      @(negedge clk); chk($sformatf("t1_motor_c%0d", c), motor_o, 1);
      cyc();
    end
    motor_done_i = 1'b0;
    @(negedge clk);
    chk("t1_motor_c6", motor_o, 0);
    chk("t1_busy_c6", busy_o, 0);
    cyc();
    check_jobs("t1");

    // T2: three nickels spaced by NICKEL_GAP low cycles
    hopper_ready_i = 1'b1;
    send(3'd3);
    do_done("t2");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cap[i]  = nickel_o;
      expv[i] = (i >= 1) && ((i - 1) % (NICKEL_GAP + 1) == 0) && ((i - 1) / (NICKEL_GAP + 1) < 3);
    end
    chk("t2_pattern", {20'd0, cap}, {20'd0, expv});
    wait_idle("t2");
    check_jobs("t2");

    // T3: third request while busy with a full queue is dropped
    send(3'd0);
    wait_motor("t3_first");
    cyc();
    soda_i = 1'b1; change_i = 3'd1; exp_q.push_back(3'd1); cyc();
    change_i = 3'd2; exp_q.push_back(3'd2); cyc();
    change_i = 3'd3; cyc();
    soda_i = 1'b0;
    @(negedge clk); chk("t3_overflow_set", overflow_o, 1);
    repeat (3) do_done("t3");
    wait_idle("t3");
    check_jobs("t3");
    chk("t3_overflow_sticky", overflow_o, 1);
    rst_n = 1'b0; #1;
    chk("t3_overflow_reset", overflow_o, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // T4: motor timeout, flush, ignored requests, clear
    soda_i = 1'b1; change_i = 3'd2; exp_q.push_back(3'd0);
    cyc();
    soda_i = 1'b0;
    wait_motor("t4");
    n = 1;
    cyc();
    soda_i = 1'b1; change_i = 3'd1;
    @(negedge clk); if (motor_o === 1'b1) n++;
    cyc();
    soda_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (motor_o === 1'b1) n++; else break;
    end
    chk("t4_motor_cycles", n, MOTOR_TIMEOUT);
    chk("t4_fault", fault_o, 1);
    chk("t4_motor_off", motor_o, 0);
    cyc();
    soda_i = 1'b1; change_i = 3'd4;
    repeat (3) cyc();
    soda_i = 1'b0;
    @(negedge clk);
    chk("t4_fault_hold", fault_o, 1);
    clear_fault_i = 1'b1;
    cyc();
    clear_fault_i = 1'b0;
    @(negedge clk);
    chk("t4_fault_clear", fault_o, 0);
    chk("t4_busy_clear", busy_o, 0);
    chk("t4_no_overflow", overflow_o, 0);
    n = 0;
    repeat (6) begin @(negedge clk); if (motor_o !== 1'b0) n++; end
    chk("t4_no_motor", n, 0);
    cyc();
    check_jobs("t4");

    // T5: change 6 clamps to 4; hopper not ready holds pulses off
    hopper_ready_i = 1'b0;
    send(3'd6);
    do_done("t5");
    n = 0;
    repeat (10) begin @(negedge clk); if (nickel_o !== 1'b0) n++; end
    chk("t5_no_pulse_unready", n, 0);
    chk("t5_busy_waiting", busy_o, 1);
    hopper_ready_i = 1'b1;
    wait_idle("t5");
    check_jobs("t5");

    // T6: reset mid-change abandons owed nickels
    send(3'd3);
    do_done("t6");
    n = 0;
    while (nickel_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t6_first_nickel", nickel_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_motor", motor_o, 0);
    chk("t6_rst_nickel", nickel_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_fault", fault_o, 0);
    exp_q.delete();
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin @(negedge clk); if (nickel_o !== 1'b0 || motor_o !== 1'b0) n++; end
    chk("t6_quiet_after_reset", n, 0);
    chk("t6_busy_after_reset", busy_o, 0);
    cyc();
    check_jobs("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
